dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Memory-side responder for the single-cycle CPU's data port.
- Accepts the CPU's MemWrite / address / write-data strobes and returns read data in the same cycle.
- Routes each access to a word-addressed data RAM or to a small memory-mapped I/O bank: GPIO, a free-running cycle counter, and a compare timer with a sticky interrupt flag.
- Sits beside the CPU at SoC top level, alongside the instruction memory.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two.
- GPIO_W, 8, width of the GPIO input and output buses.
- TIMER_CMP_RST, 32'hFFFF_FFFF, reset value of the TIMER_CMP register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mem_we  input  1  write strobe from CPU (MemWrite).
- mem_addr  input  32  byte address from CPU (Mem_WrAddr).
- mem_wdata  input  32  write data from CPU (Mem_WrData).
- mem_rdata  output  32  read data to CPU (ReadData); combinational.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  registered GPIO outputs.
- timer_irq  output  1  level interrupt = timer match flag.

Behaviour:
- **Access model:** full 32-bit words only. mem_addr[1:0] is ignored.
- **Reads:** combinational from mem_addr, zero wait states. mem_rdata is valid in the same cycle; mem_we does not gate reads.
- **Writes:** take effect at the rising clk edge while mem_we=1. A read of the same address in that cycle returns the old value.
- **Decode:**
  - mem_addr[31]=0: RAM. Word index = mem_addr[log2(RAM_WORDS)+1:2]; higher bits are ignored, so the RAM aliases.
  - mem_addr[31]=1 and mem_addr[30:5]=0: MMIO, offset mem_addr[4:2].
  - Anything else: unmapped. Reads return 0; writes are ignored.
- **MMIO map (byte offsets):**
  - 0x00 GPIO_OUT, RW. Low GPIO_W bits are stored; read returns the zero-extended value.
  - 0x04 GPIO_IN, RO. Value of the 2-flop synchronizer on gpio_in, zero-extended.
  - 0x08 CYCLE, RW. 32-bit counter; increments every cycle and wraps 0xFFFF_FFFF -> 0. A write loads mem_wdata and overrides that cycle's increment.
  - 0x0C TIMER_CMP, RW.
  - 0x10 TIMER_STAT, bit0 = match flag. Write 1 to bit0 clears it; writing 0 has no effect. Other bits read 0.
  - 0x14–0x1C: read 0, writes ignored.
- **Timer flag:**
  - At each edge, if the pre-update CYCLE value equals TIMER_CMP, the flag sets to 1.
  - The flag is sticky.
  - Set and W1C in the same cycle: set wins.
  - A write to TIMER_CMP compares against the new value from the next cycle onward.
- **timer_irq:** equals the flag register; no combinational path from the bus.
- **Reset (reset=0, asynchronous):**
  - gpio_out=0, CYCLE=0, TIMER_CMP=TIMER_CMP_RST, flag=0, timer_irq=0, synchronizer flops=0.
  - RAM contents are not reset and are undefined until written.
  - mem_rdata still follows decode combinationally; MMIO reads return the reset values.
- **Reset mid-operation:** a write in the reset-deassertion cycle is dropped if reset is still low at that edge. After reset rises, CYCLE reads 0 in the first cycle and 1 in the next.
- **GPIO_IN latency:** a change on gpio_in is visible through 0x04 after exactly 2 rising edges.

Test Plan:
- **Reset values:** hold reset=0 for 3 cycles, release. Read 0x8000_0000 -> 0, 0x8000_000C -> 0xFFFF_FFFF, 0x8000_0010 -> 0; timer_irq=0; CYCLE reads 0 then 1 on consecutive cycles.
- **RAM write and alias:**
  - Write 0xDEAD_BEEF to 0x0000_0010.
  - Same cycle: read returns old data.
  - Next cycle: read 0x0000_0010 -> 0xDEAD_BEEF.
  - With RAM_WORDS=64, read 0x0000_0110 (alias) -> 0xDEAD_BEEF, and read 0x0000_0013 -> 0xDEAD_BEEF.
- **GPIO:**
  - Write 0x1A5 to 0x8000_0000 -> gpio_out=0xA5 after the edge; read -> 0x0000_00A5.
  - Set gpio_in=0x3C -> 0x8000_0004 reads 0x3C after exactly 2 edges, not after 1.
- **Timer match:**
  - Write TIMER_CMP=20, then write CYCLE=15 -> flag and timer_irq rise at the edge where CYCLE goes 20->21.
  - Write 0 to 0x8000_0010 -> flag stays set.
  - Write 1 -> flag clears.
- **Set wins over clear:** with TIMER_CMP equal to the current CYCLE value, write 1 to TIMER_STAT in that same cycle -> flag is 1 after the edge.
- **Wrap and unmapped:**
  - Write CYCLE=0xFFFF_FFFF -> reads 0 next cycle.
  - Write 0x1234 to 0x8000_0040 and 0x8000_0014 -> reads of both return 0, and no other register or RAM word changes.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-port responder for the single-cycle CPU: word-addressed RAM plus a small
// MMIO bank (GPIO out/in, free-running cycle counter, compare timer with sticky flag).
// Reads are combinational; writes commit at the rising clock edge.
module dmem_mmio_responder #(
    parameter int unsigned RAM_WORDS     = 64,
    parameter int unsigned GPIO_W        = 8,
    parameter logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_CYCLE    = 3'd2;
    localparam logic [2:0] OFF_CMP      = 3'd3;
    localparam logic [2:0] OFF_STAT     = 3'd4;

    logic [31:0]       ram [RAM_WORDS];
    logic [AW-1:0]     ram_idx;
    logic              is_ram;
    logic              is_mmio;
    logic [2:0]        mmio_off;
    logic              ram_wr;
    logic              mmio_wr;

    logic [GPIO_W-1:0] gpio_out_r;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [31:0]       cycle_cnt;
    logic [31:0]       timer_cmp;
    logic              match_flag;
    logic              timer_hit;
    logic              stat_clr;

    // Byte-lane bits are meaningless for word-only accesses.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[1:0];

    // Address decode: RAM aliases across the whole lower half; MMIO occupies 32 bytes.
    always_comb begin
        is_ram   = ~mem_addr[31];
        is_mmio  = mem_addr[31] && (mem_addr[30:5] == '0);
        mmio_off = mem_addr[4:2];
        ram_idx  = mem_addr[AW+1:2];
        ram_wr   = mem_we && is_ram;
        mmio_wr  = mem_we && is_mmio;
        stat_clr = mmio_wr && (mmio_off == OFF_STAT) && mem_wdata[0];
        // CYCLE is compared before its own update, so a same-edge CYCLE write
        // still lets the old value set the flag.
        timer_hit = (cycle_cnt == timer_cmp);
    end

    // RAM write port; gated by reset so writes while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (reset && ram_wr) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    // MMIO registers, GPIO synchronizer, cycle counter and sticky timer flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_r <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
            cycle_cnt  <= '0;
            timer_cmp  <= TIMER_CMP_RST;
            match_flag <= 1'b0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;

            if (mmio_wr && (mmio_off == OFF_GPIO_OUT)) begin
                gpio_out_r <= mem_wdata[GPIO_W-1:0];
            end

            if (mmio_wr && (mmio_off == OFF_CYCLE)) begin
                cycle_cnt <= mem_wdata;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (mmio_wr && (mmio_off == OFF_CMP)) begin
                timer_cmp <= mem_wdata;
            end

            if (timer_hit) begin
                match_flag <= 1'b1;
            end else if (stat_clr) begin
                match_flag <= 1'b0;
            end
        end
    end

    // Combinational read mux; unmapped and reserved locations read as zero.
    always_comb begin
        mem_rdata = '0;
        if (is_ram) begin
            mem_rdata = ram[ram_idx];
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_GPIO_OUT: mem_rdata = 32'(gpio_out_r);
                OFF_GPIO_IN:  mem_rdata = 32'(gpio_sync2);
                OFF_CYCLE:    mem_rdata = cycle_cnt;
                OFF_CMP:      mem_rdata = timer_cmp;
                OFF_STAT:     mem_rdata = {31'b0, match_flag};
                default:      mem_rdata = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_out_r;
    assign timer_irq = match_flag;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: expected values are queued on a
// scoreboard as stimulus is driven and popped when the DUT output is sampled.
module tb_dmem_mmio_responder;

    logic        clk;
    logic        reset;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    logic [31:0] sb[$];
    logic [31:0] obs;
    logic [31:0] e;
    int unsigned n_checks;
    int unsigned n_fails;

    dmem_mmio_responder #(
        .RAM_WORDS(64),
        .GPIO_W(8),
        .TIMER_CMP_RST(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        mem_we   = 1'b0;
        mem_addr = a;
        #1;
        v = mem_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        step();
        mem_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(32'h0); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_cycle0: got %h expected %h", obs, e); end
        sb.push_back(32'h0); rd(32'h8000_0000, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_gpio_out: got %h expected %h", obs, e); end
        sb.push_back(32'hFFFF_FFFF); rd(32'h8000_000C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_cmp: got %h expected %h", obs, e); end
        sb.push_back(32'h0); rd(32'h8000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_stat: got %h expected %h", obs, e); end
        sb.push_back(32'h0); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_irq: got %h expected %h", obs, e); end
        step();
        sb.push_back(32'h1); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reset_cycle1: got %h expected %h", obs, e); end
    endtask

    task automatic test_ram();
        wr(32'h0000_0010, 32'h1111_1111);
        mem_addr = 32'h0000_0010; mem_wdata = 32'hDEAD_BEEF; mem_we = 1'b1;
        #1;
        sb.push_back(32'h1111_1111); obs = mem_rdata; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL ram_same_cycle_old: got %h expected %h", obs, e); end
        step();
        mem_we = 1'b0;
        sb.push_back(32'hDEAD_BEEF); rd(32'h0000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL ram_read: got %h expected %h", obs, e); end
        sb.push_back(32'hDEAD_BEEF); rd(32'h0000_0110, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL ram_alias: got %h expected %h", obs, e); end
        sb.push_back(32'hDEAD_BEEF); rd(32'h0000_0013, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL ram_byte_ignored: got %h expected %h", obs, e); end
    endtask

    task automatic test_gpio();
        wr(32'h8000_0000, 32'h0000_01A5);
        sb.push_back(32'hA5); obs = 32'(gpio_out); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL gpio_out_pin: got %h expected %h", obs, e); end
        sb.push_back(32'h0000_00A5); rd(32'h8000_0000, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL gpio_out_read: got %h expected %h", obs, e); end
        gpio_in = 8'h3C;
        step();
        sb.push_back(32'h0); rd(32'h8000_0004, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL gpio_in_1edge: got %h expected %h", obs, e); end
        step();
        sb.push_back(32'h3C); rd(32'h8000_0004, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL gpio_in_2edge: got %h expected %h", obs, e); end
    endtask

    task automatic test_timer_match();
        wr(32'h8000_0008, 32'd15);
        wr(32'h8000_000C, 32'd20);
        sb.push_back(32'd16); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_cycle16: got %h expected %h", obs, e); end
        repeat (4) step();
        sb.push_back(32'd20); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_cycle20: got %h expected %h", obs, e); end
        sb.push_back(32'h0); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_irq_before: got %h expected %h", obs, e); end
        step();
        sb.push_back(32'h1); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_irq_set: got %h expected %h", obs, e); end
        sb.push_back(32'h1); rd(32'h8000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_stat_set: got %h expected %h", obs, e); end
        wr(32'h8000_0010, 32'h0);
        sb.push_back(32'h1); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_w0_sticky: got %h expected %h", obs, e); end
        wr(32'h8000_0010, 32'h1);
        sb.push_back(32'h0); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_w1c_irq: got %h expected %h", obs, e); end
        sb.push_back(32'h0); rd(32'h8000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL timer_w1c_stat: got %h expected %h", obs, e); end
    endtask

    task automatic test_set_wins();
        wr(32'h8000_0008, 32'd49);
        wr(32'h8000_000C, 32'd50);
        sb.push_back(32'h0); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL setwins_pre: got %h expected %h", obs, e); end
        wr(32'h8000_0010, 32'h1);
        sb.push_back(32'h1); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL setwins_irq: got %h expected %h", obs, e); end
        sb.push_back(32'h1); rd(32'h8000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL setwins_stat: got %h expected %h", obs, e); end
    endtask

    task automatic test_wrap_unmapped();
        wr(32'h8000_0008, 32'hFFFF_FFFF);
        sb.push_back(32'hFFFF_FFFF); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL wrap_load: got %h expected %h", obs, e); end
        step();
        sb.push_back(32'h0); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL wrap_zero: got %h expected %h", obs, e); end
        wr(32'h0000_0040, 32'h5555_AAAA);
        wr(32'h8000_0040, 32'h0000_1234);
        wr(32'h8000_0014, 32'h0000_1234);
        sb.push_back(32'h0); rd(32'h8000_0040, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL unmapped_read: got %h expected %h", obs, e); end
        sb.push_back(32'h0); rd(32'h8000_0014, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL reserved_read: got %h expected %h", obs, e); end
        sb.push_back(32'h5555_AAAA); rd(32'h0000_0040, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL unmapped_ram40: got %h expected %h", obs, e); end
        sb.push_back(32'hDEAD_BEEF); rd(32'h0000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL unmapped_ram10: got %h expected %h", obs, e); end
        sb.push_back(32'hA5); rd(32'h8000_0000, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL unmapped_gpio: got %h expected %h", obs, e); end
        sb.push_back(32'd50); rd(32'h8000_000C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL unmapped_cmp: got %h expected %h", obs, e); end
    endtask

    task automatic test_reset_midop();
        reset = 1'b0;
        sb.push_back(32'h0); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_cycle: got %h expected %h", obs, e); end
        sb.push_back(32'hFFFF_FFFF); rd(32'h8000_000C, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_cmp: got %h expected %h", obs, e); end
        sb.push_back(32'h0); obs = {31'b0, timer_irq}; e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_irq: got %h expected %h", obs, e); end
        wr(32'h8000_0000, 32'h0000_00FF);
        mem_addr = 32'h0000_0010; mem_wdata = 32'h0; mem_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_we = 1'b0;
        reset  = 1'b1;
        sb.push_back(32'h0); obs = 32'(gpio_out); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_gpio_dropped: got %h expected %h", obs, e); end
        sb.push_back(32'hDEAD_BEEF); rd(32'h0000_0010, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_ram_dropped: got %h expected %h", obs, e); end
        sb.push_back(32'h0); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_cycle0: got %h expected %h", obs, e); end
        step();
        sb.push_back(32'h1); rd(32'h8000_0008, obs); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fails++; $display("FAIL midrst_cycle1: got %h expected %h", obs, e); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_ram();
        test_gpio();
        test_timer_match();
        test_set_wins();
        test_wrap_unmapped();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
